// File: rtl/boid_plotter_if.sv
// Bundle between the boid plotter, the boid position memory and the framebuffer write port.
// master = plotter side, slave = memory/framebuffer/controller side.
interface boid_plotter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int X_WIDTH    = 5,
    parameter int Y_WIDTH    = 5,
    parameter int IDX_WIDTH  = 3
);
    logic                  frame_start;
    logic [IDX_WIDTH-1:0]  boid_addr;
    logic [X_WIDTH-1:0]    boid_x;
    logic [Y_WIDTH-1:0]    boid_y;
    logic                  fb_swap;
    logic                  fb_we;
    logic [ADDR_WIDTH-1:0] fb_write_addr;
    logic                  fb_write_data;
    logic                  busy;
    logic                  done;
    logic                  overrun;

    modport master (
        input  frame_start,
        input  boid_x,
        input  boid_y,
        output boid_addr,
        output fb_swap,
        output fb_we,
        output fb_write_addr,
        output fb_write_data,
        output busy,
        output done,
        output overrun
    );

    modport slave (
        output frame_start,
        output boid_x,
        output boid_y,
        input  boid_addr,
        input  fb_swap,
        input  fb_we,
        input  fb_write_addr,
        input  fb_write_data,
        input  busy,
        input  done,
        input  overrun
    );
endinterface

// File: rtl/boid_plotter.sv
// Rasterises every boid as a SPRITE x SPRITE square into the back framebuffer, one pixel per cycle,
// after pulsing the buffer swap at the start of each frame.
module boid_plotter #(
    parameter int FB_WIDTH   = 32,
    parameter int FB_HEIGHT  = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int X_WIDTH    = 5,
    parameter int Y_WIDTH    = 5,
    parameter int NUM_BOIDS  = 8,
    parameter int IDX_WIDTH  = 3,
    parameter int SPRITE     = 2
) (
    input  logic          clk,
    input  logic          reset,
    boid_plotter_if.master bus
);
    localparam int DW = (SPRITE > 1) ? $clog2(SPRITE) : 1;
    localparam logic [DW-1:0]        D_LAST   = DW'(SPRITE - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_BOIDS - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SWAP  = 3'd1;
    localparam logic [2:0] FETCH = 3'd2;
    localparam logic [2:0] LATCH = 3'd3;
    localparam logic [2:0] DRAW  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]            state_reg, state_next;
    logic [IDX_WIDTH-1:0]  idx_reg, idx_next;
    logic [X_WIDTH-1:0]    bx_reg, bx_next;
    logic [Y_WIDTH-1:0]    by_reg, by_next;
    logic [DW-1:0]         dx_reg, dx_next;
    logic [DW-1:0]         dy_reg, dy_next;
    logic                  overrun_reg, overrun_next;
    logic                  fb_swap_reg;
    logic                  fb_we_reg, fb_we_next;
    logic [ADDR_WIDTH-1:0] fb_write_addr_reg, fb_write_addr_next;
    logic                  busy_reg;
    logic                  done_reg;

    logic                  last_pixel;
    logic                  last_boid;
    logic [X_WIDTH:0]      px_next;
    logic [Y_WIDTH:0]      py_next;
    logic                  pixel_on_screen;

    assign last_pixel = (dx_reg == D_LAST) && (dy_reg == D_LAST);
    assign last_boid  = (idx_reg == IDX_LAST);

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        bx_next      = bx_reg;
        by_next      = by_reg;
        dx_next      = dx_reg;
        dy_next      = dy_reg;
        overrun_next = overrun_reg;

        case (state_reg)
            IDLE: begin
                if (bus.frame_start) begin
                    state_next = SWAP;
                end
            end
            SWAP: begin
                idx_next   = '0;
                state_next = FETCH;
            end
            FETCH: begin
                state_next = LATCH;
            end
            LATCH: begin
                bx_next    = bus.boid_x;
                by_next    = bus.boid_y;
                dx_next    = '0;
                dy_next    = '0;
                state_next = DRAW;
            end
            DRAW: begin
                if (last_pixel) begin
                    dx_next = '0;
                    dy_next = '0;
                    if (last_boid) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx_reg + IDX_WIDTH'(1);
                        state_next = FETCH;
                    end
                end else if (dx_reg == D_LAST) begin
                    dx_next = '0;
                    dy_next = dy_reg + DW'(1);
                end else begin
                    dx_next = dx_reg + DW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A new frame always wins: abandon whatever is in flight and restart from boid 0.
        if (bus.frame_start) begin
            if (state_reg != IDLE) begin
                overrun_next = 1'b1;
            end
            state_next = SWAP;
            idx_next   = '0;
        end
    end

    // Pixel maths is done on the next-cycle coordinates so the write port can be registered.
    assign px_next = {1'b0, bx_next} + (X_WIDTH + 1)'(dx_next);
    assign py_next = {1'b0, by_next} + (Y_WIDTH + 1)'(dy_next);
    assign pixel_on_screen = (32'(px_next) < 32'(FB_WIDTH)) && (32'(py_next) < 32'(FB_HEIGHT));

    assign fb_we_next         = (state_next == DRAW) && pixel_on_screen;
    assign fb_write_addr_next = ADDR_WIDTH'(py_next) * ADDR_WIDTH'(FB_WIDTH) + ADDR_WIDTH'(px_next);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            idx_reg           <= '0;
            bx_reg            <= '0;
            by_reg            <= '0;
            dx_reg            <= '0;
            dy_reg            <= '0;
            overrun_reg       <= 1'b0;
            fb_swap_reg       <= 1'b0;
            fb_we_reg         <= 1'b0;
            fb_write_addr_reg <= '0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
        end else begin
            state_reg         <= state_next;
            idx_reg           <= idx_next;
            bx_reg            <= bx_next;
            by_reg            <= by_next;
            dx_reg            <= dx_next;
            dy_reg            <= dy_next;
            overrun_reg       <= overrun_next;
            fb_swap_reg       <= (state_next == SWAP);
            fb_we_reg         <= fb_we_next;
            fb_write_addr_reg <= fb_write_addr_next;
            busy_reg          <= (state_next != IDLE);
            done_reg          <= (state_next == DONE);
        end
    end

    assign bus.boid_addr     = idx_reg;
    assign bus.fb_swap       = fb_swap_reg;
    assign bus.fb_we         = fb_we_reg;
    assign bus.fb_write_addr = fb_write_addr_reg;
    assign bus.fb_write_data = fb_we_reg;
    assign bus.busy          = busy_reg;
    assign bus.done          = done_reg;
    assign bus.overrun       = overrun_reg;
endmodule

// File: tb/tb_boid_plotter.sv
// Randomised frame-level check of boid_plotter against a cycle-position model of the rasteriser,
// plus a small SPRITE=1 single-boid instance.
module tb_boid_plotter;
    localparam int N      = 8;
    localparam int S      = 2;
    localparam int W      = 32;
    localparam int H      = 32;
    localparam int PER    = 2 + S * S;
    localparam int DONE_T = 2 + N * PER;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    boid_plotter_if #(.ADDR_WIDTH(10), .X_WIDTH(5), .Y_WIDTH(5), .IDX_WIDTH(3)) bus ();
    boid_plotter_if #(.ADDR_WIDTH(10), .X_WIDTH(5), .Y_WIDTH(5), .IDX_WIDTH(3)) bus1 ();

    boid_plotter #(
        .FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_WIDTH(10), .X_WIDTH(5), .Y_WIDTH(5),
        .NUM_BOIDS(N), .IDX_WIDTH(3), .SPRITE(S)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    boid_plotter #(
        .FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_WIDTH(10), .X_WIDTH(5), .Y_WIDTH(5),
        .NUM_BOIDS(1), .IDX_WIDTH(3), .SPRITE(1)
    ) dut1 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus1.master)
    );

    int   mem_x [N];
    int   mem_y [N];
    int   total = 0;
    int   bad   = 0;
    int   frames = 0;
    int   nwrites;
    logic exp_overrun;

    // Boid position memory with one cycle of read latency.
    always @(posedge clk) begin
        bus.boid_x <= 5'(mem_x[bus.boid_addr]);
        bus.boid_y <= 5'(mem_y[bus.boid_addr]);
    end
    assign bus1.boid_x = 5'd5;
    assign bus1.boid_y = 5'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs in cycle t of a frame (t=1 is the cycle after frame_start was sampled).
    task automatic check_cycle(input int t);
        int   i, ph, k, px, py;
        logic we_exp;
        we_exp = 1'b0;
        check($sformatf("swap t=%0d", t), bus.fb_swap, (t == 1));
        check($sformatf("busy t=%0d", t), bus.busy, (t >= 1 && t <= DONE_T));
        check($sformatf("done t=%0d", t), bus.done, (t == DONE_T));
        check($sformatf("overrun t=%0d", t), bus.overrun, exp_overrun);
        if (t >= 2 && t < DONE_T) begin
            i  = (t - 2) / PER;
            ph = (t - 2) % PER;
            if (ph == 0) begin
                check($sformatf("boid_addr t=%0d", t), bus.boid_addr, i);
            end
            if (ph >= 2) begin
                k  = ph - 2;
                px = mem_x[i] + k % S;
                py = mem_y[i] + k / S;
                we_exp = (px < W) && (py < H);
                if (we_exp) begin
                    nwrites++;
                    check($sformatf("addr t=%0d", t), bus.fb_write_addr, py * W + px);
                end
            end
        end
        check($sformatf("we t=%0d", t), bus.fb_we, we_exp);
        check($sformatf("wdata t=%0d", t), bus.fb_write_data, we_exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " boid_addr"}, bus.boid_addr, 0);
        check({tag, " swap"}, bus.fb_swap, 0);
        check({tag, " we"}, bus.fb_we, 0);
        check({tag, " addr"}, bus.fb_write_addr, 0);
        check({tag, " wdata"}, bus.fb_write_data, 0);
        check({tag, " busy"}, bus.busy, 0);
        check({tag, " done"}, bus.done, 0);
        check({tag, " overrun"}, bus.overrun, 0);
    endtask

    // Must be entered just after a negedge; returns just after a negedge.
    task automatic run_frame(input int abort_at, input int reset_at);
        int t;
        int abort;
        abort   = abort_at;
        nwrites = 0;
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        t = 1;
        while (t <= DONE_T + 1) begin
            check_cycle(t);
            if (abort != 0 && t == abort) begin
                abort       = 0;
                exp_overrun = 1'b1;
                nwrites     = 0;
                bus.frame_start = 1'b1;
                @(negedge clk);
                bus.frame_start = 1'b0;
                t = 1;
            end else if (reset_at != 0 && t == reset_at) begin
                #1 reset = 1'b1;
                #1 check_all_zero("async_reset");
                exp_overrun = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                t = DONE_T + 2;
            end else begin
                @(negedge clk);
                t++;
            end
        end
        frames++;
        $display("frame %0d: abort_at=%0d reset_at=%0d writes=%0d overrun=%0d",
                 frames, abort_at, reset_at, nwrites, exp_overrun);
    endtask

    task automatic randomise_boids();
        for (int i = 0; i < N; i++) begin
            mem_x[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(29, 31)) : int'($urandom_range(0, 31));
            mem_y[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(29, 31)) : int'($urandom_range(0, 31));
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus.frame_start  = 1'b0;
        bus1.frame_start = 1'b0;
        exp_overrun      = 1'b0;
        for (int i = 0; i < N; i++) begin
            mem_x[i] = 0;
            mem_y[i] = 0;
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset s1 busy", bus1.busy, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed corners: (3,4) first, screen edges and the bottom-right pixel.
        mem_x = '{3, 31, 30, 31, 0, 15, 31, 7};
        mem_y = '{4, 31, 31, 0, 31, 16, 30, 7};
        run_frame(0, 0);

        for (int i = 0; i < N; i++) begin
            mem_x[i] = 2 * i;
            mem_y[i] = 0;
        end
        run_frame(0, 0);

        repeat (4) begin
            randomise_boids();
            repeat (2) @(negedge clk);
            run_frame(0, 0);
        end

        randomise_boids();
        run_frame(20, 0);
        randomise_boids();
        run_frame(0, 0);
        run_frame(DONE_T, 0);

        mem_x[0] = 3;
        mem_y[0] = 4;
        run_frame(0, 6);
        randomise_boids();
        run_frame(0, 0);

        // SPRITE=1, one boid at (5,0): one write to address 5, five busy cycles.
        bus1.frame_start = 1'b1;
        @(negedge clk);
        bus1.frame_start = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            check($sformatf("s1 swap t=%0d", t), bus1.fb_swap, (t == 1));
            check($sformatf("s1 busy t=%0d", t), bus1.busy, (t <= 5));
            check($sformatf("s1 done t=%0d", t), bus1.done, (t == 5));
            check($sformatf("s1 we t=%0d", t), bus1.fb_we, (t == 4));
            if (t == 4) begin
                check("s1 addr", bus1.fb_write_addr, 5);
            end
            check($sformatf("s1 overrun t=%0d", t), bus1.overrun, 0);
            @(negedge clk);
        end
        $display("frame s1: sprite=1 single boid checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/boid_plotter.md
Name: boid_plotter

Overview:
- Upstream stage of the double-buffered 1-bit boid framebuffer. On each frame_start it pulses the framebuffer's buffer-swap input.
- It then walks the boid position memory and rasterises every boid as a SPRITE x SPRITE square of set pixels.
- It drives the framebuffer write port (we / write_addr / write_data) one pixel per cycle, and clips pixels that fall outside the screen.

Parameters:
- FB_WIDTH, 32, framebuffer width in pixels (power of two).
- FB_HEIGHT, 32, framebuffer height in pixels.
- ADDR_WIDTH, 10, framebuffer address width; FB_WIDTH*FB_HEIGHT <= 2^ADDR_WIDTH.
- X_WIDTH, 5, boid x coordinate width.
- Y_WIDTH, 5, boid y coordinate width.
- NUM_BOIDS, 8, boids plotted per frame (>=1).
- IDX_WIDTH, 3, boid index width; 2^IDX_WIDTH >= NUM_BOIDS.
- SPRITE, 2, square side in pixels (1..4).

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- frame_start  in  1  single-cycle pulse marking start of a new frame (e.g. VSYNC edge).
- boid_addr  out  IDX_WIDTH  read index into boid position memory.
- boid_x  in  X_WIDTH  x of boid at boid_addr; valid 1 cycle after boid_addr.
- boid_y  in  Y_WIDTH  y of boid at boid_addr; valid 1 cycle after boid_addr.
- fb_swap  out  1  1-cycle pulse to the framebuffer swap input.
- fb_we  out  1  framebuffer write enable.
- fb_write_addr  out  ADDR_WIDTH  pixel address, y*FB_WIDTH + x.
- fb_write_data  out  1  pixel value; 1 when fb_we, else 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  1-cycle pulse when all boids of the frame are plotted.
- overrun  out  1  sticky; set when frame_start arrives while busy.

Behaviour:
Reset:
- Async reset forces state=IDLE.
- All outputs are 0: boid_addr, fb_swap, fb_we, fb_write_addr, fb_write_data, busy, done, overrun.
- Internal index, dx, dy and latched x/y are 0.

State machine (registered outputs):
- IDLE: wait. frame_start=1 -> SWAP.
- SWAP: fb_swap=1 for exactly this cycle. idx<=0, boid_addr<=0. Next state FETCH.
- FETCH: boid_addr=idx is stable; memory is read this cycle. Next state LATCH.
- LATCH: capture bx<=boid_x, by<=boid_y; dx<=0, dy<=0. Next state DRAW.
- DRAW: one cycle per pixel, SPRITE*SPRITE cycles per boid.
  - Pixel coordinate is px=bx+dx, py=by+dy, computed without truncation (width+1 bits).
  - fb_we=1 iff px<FB_WIDTH and py<FB_HEIGHT; clipped pixels still consume their cycle with fb_we=0.
  - fb_write_addr = py*FB_WIDTH+px, truncated to ADDR_WIDTH; it may hold any value when fb_we=0.
  - dx increments first; on wrap dx<=0 and dy increments (raster order).
  - Last pixel, idx<NUM_BOIDS-1: idx++, boid_addr<=idx+1, next state FETCH.
  - Last pixel, idx=NUM_BOIDS-1: next state DONE.
- DONE: done=1 for this cycle. Next state IDLE.

Latency:
- frame_start seen at edge N gives fb_swap high in cycle N+1.
- Total busy cycles = 2 + NUM_BOIDS*(2+SPRITE^2).

Frame_start while busy (any non-IDLE state):
- Current frame is abandoned and overrun<=1.
- Next state SWAP (new swap pulse, restart from idx 0).
- No done pulse for the abandoned frame.
- frame_start in DONE also counts as overrun.

Other rules:
- Reset asserted mid-DRAW: fb_we drops asynchronously to 0 and the block returns to IDLE.
- No handshake with the framebuffer: writes are always accepted.
- The caller guarantees frame_start spacing >= 2^ADDR_WIDTH cycles, so the clear sweep of the inactive buffer completes.
- Duplicate or overlapping boids write the same address repeatedly; this is legal.

Test Plan:
1. Defaults, NUM_BOIDS=1, boid0=(3,4), frame_start at edge 0 -> fb_swap in cycle 1 only.
   - fb_we writes addr 131,132,163,164 in cycles 4..7.
   - done in cycle 8; busy cycles 1..8.
2. Boid at (31,31) -> only addr 1023 written (dx=0,dy=0); the other 3 DRAW cycles have fb_we=0; no addr wrap to row 0.
3. NUM_BOIDS=8, boids (0,0),(2,0)..(14,0) -> 32 writes, boid_addr steps 0..7; done in cycle 1+1+8*6 = 50.
4. frame_start again at cycle 20 -> overrun=1 and stays 1; fb_swap in cycle 21; idx restarts at 0; single done at cycle 70.
5. Reset asserted mid-DRAW at cycle 6 -> all outputs 0 immediately. After release, frame_start replots the full frame normally with overrun=0.
6. SPRITE=1, boid (5,0) -> exactly one write, addr 5; busy 2+1*3=5 cycles.
